// File: rtl/mc_control_pkg.sv
// Shared definitions for the multi-cycle TSC control FSM: state encodings,
// ISA opcode/funcode constants, datapath select codes and instruction classes.
package mc_control_pkg;

    typedef enum logic [2:0] {
        S_IF   = 3'd0,
        S_ID   = 3'd1,
        S_EX   = 3'd2,
        S_MEM  = 3'd3,
        S_WB   = 3'd4,
        S_HALT = 3'd5
    } state_t;

    localparam logic [3:0] OP_BNE   = 4'd0;
    localparam logic [3:0] OP_BEQ   = 4'd1;
    localparam logic [3:0] OP_BGZ   = 4'd2;
    localparam logic [3:0] OP_BLZ   = 4'd3;
    localparam logic [3:0] OP_ADI   = 4'd4;
    localparam logic [3:0] OP_ORI   = 4'd5;
    localparam logic [3:0] OP_LHI   = 4'd6;
    localparam logic [3:0] OP_LWD   = 4'd7;
    localparam logic [3:0] OP_SWD   = 4'd8;
    localparam logic [3:0] OP_JMP   = 4'd9;
    localparam logic [3:0] OP_JAL   = 4'd10;
    localparam logic [3:0] OP_RTYPE = 4'd15;

    localparam logic [5:0] FN_JPR = 6'd25;
    localparam logic [5:0] FN_JRL = 6'd26;
    localparam logic [5:0] FN_WWD = 6'd28;
    localparam logic [5:0] FN_HLT = 6'd29;

    // ALU setting used for PC+1 and as the idle default
    localparam logic [3:0] ALU_OP_ADD = 4'd15;
    localparam logic [5:0] ALU_FN_ADD = 6'd0;

    localparam logic [1:0] PC_SRC_ALU = 2'd0;
    localparam logic [1:0] PC_SRC_BR  = 2'd1;
    localparam logic [1:0] PC_SRC_JMP = 2'd2;
    localparam logic [1:0] PC_SRC_RS  = 2'd3;

    localparam logic [1:0] ALU_B_RT   = 2'd0;
    localparam logic [1:0] ALU_B_ONE  = 2'd1;
    localparam logic [1:0] ALU_B_SEXT = 2'd2;
    localparam logic [1:0] ALU_B_ZEXT = 2'd3;

    localparam logic [1:0] REG_DST_RT = 2'd0;
    localparam logic [1:0] REG_DST_RD = 2'd1;
    localparam logic [1:0] REG_DST_R2 = 2'd2;

    localparam logic [1:0] M2R_ALU = 2'd0;
    localparam logic [1:0] M2R_MDR = 2'd1;
    localparam logic [1:0] M2R_PC  = 2'd2;

    typedef enum logic [3:0] {
        C_BR, C_RALU, C_ADI, C_IMMZ, C_LWD, C_SWD, C_JMP,
        C_JAL, C_JPR, C_JRL, C_WWD, C_HLT, C_UND
    } iclass_t;

    function automatic iclass_t decode_class(
        input logic [3:0] opcode,
        input logic [5:0] funcode
    );
        iclass_t ic;
        ic = C_UND;
        case (opcode)
            OP_BNE, OP_BEQ, OP_BGZ, OP_BLZ: ic = C_BR;
            OP_ADI:         ic = C_ADI;
            OP_ORI, OP_LHI: ic = C_IMMZ;
            OP_LWD:         ic = C_LWD;
            OP_SWD:         ic = C_SWD;
            OP_JMP:         ic = C_JMP;
            OP_JAL:         ic = C_JAL;
            OP_RTYPE: begin
                if (funcode[5:3] == 3'd0) begin
                    ic = C_RALU;
                end else begin
                    case (funcode)
                        FN_JPR:  ic = C_JPR;
                        FN_JRL:  ic = C_JRL;
                        FN_WWD:  ic = C_WWD;
                        FN_HLT:  ic = C_HLT;
                        default: ic = C_UND;
                    endcase
                end
            end
            default: ic = C_UND;
        endcase
        return ic;
    endfunction

endpackage

// File: rtl/mc_next_state.sv
// Next-state logic of the multi-cycle control FSM (purely combinational).
// Ports: state, opcode, funcode, mem_ready in; state_d, retire out.
module mc_next_state
    import mc_control_pkg::*;
(
    input  state_t     state,
    input  logic [3:0] opcode,
    input  logic [5:0] funcode,
    input  logic       mem_ready,
    output state_t     state_d,
    output logic       retire
);

    iclass_t ic;

    always_comb begin
        ic      = decode_class(opcode, funcode);
        state_d = state;
        case (state)
            S_IF: begin
                if (mem_ready) state_d = S_ID;
            end
            S_ID: begin
                case (ic)
                    C_JMP, C_UND: state_d = S_IF;
                    C_JAL:        state_d = S_WB;
                    C_HLT:        state_d = S_HALT;
                    default:      state_d = S_EX;
                endcase
            end
            S_EX: begin
                case (ic)
                    C_BR, C_WWD, C_JPR: state_d = S_IF;
                    C_LWD, C_SWD:       state_d = S_MEM;
                    default:            state_d = S_WB;
                endcase
            end
            S_MEM: begin
                if (mem_ready) state_d = (ic == C_LWD) ? S_WB : S_IF;
            end
            S_WB:    state_d = S_IF;
            S_HALT:  state_d = S_HALT;
            default: state_d = S_IF;
        endcase
        // an instruction retires on every entry into IF; IF wait cycles do not
        retire = (state_d == S_IF) && (state != S_IF);
    end

endmodule

// File: rtl/mc_control.sv
// Multi-cycle control FSM for the 16-bit TSC CPU: state register, Moore output
// decode and optional retired-instruction counter (macro INST_COUNT_EN).
// Inputs: clk, reset (async, active-high), opcode, funcode, bcond, mem_ready.
// Outputs: memory strobes, IR/PC write controls, ALU controls, writeback
// selects, out_write, halted and (with INST_COUNT_EN) num_inst.
module mc_control
    import mc_control_pkg::*;
#(
    parameter int WORD_SIZE = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] opcode,
    input  logic [5:0] funcode,
    input  logic       bcond,
    input  logic       mem_ready,
    output logic       mem_read,
    output logic       mem_write,
    output logic       i_or_d,
    output logic       ir_write,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic [1:0] pc_src,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [3:0] alu_opcode,
    output logic [5:0] alu_funcode,
    output logic       reg_write,
    output logic [1:0] reg_dst,
    output logic [1:0] mem_to_reg,
    output logic       out_write,
    output logic       halted
`ifdef INST_COUNT_EN
    ,
    output logic [WORD_SIZE-1:0] num_inst
`endif
);

    state_t  state_q;
    state_t  state_d;
    logic    retire;
    iclass_t ic;

    mc_next_state u_next_state (
        .state     (state_q),
        .opcode    (opcode),
        .funcode   (funcode),
        .mem_ready (mem_ready),
        .state_d   (state_d),
        .retire    (retire)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= S_IF;
        else       state_q <= state_d;
    end

    // bcond is combined with pc_write_cond in the datapath
    logic unused_bcond;
    assign unused_bcond = bcond;

    always_comb begin
        ic            = decode_class(opcode, funcode);
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        i_or_d        = 1'b0;
        ir_write      = 1'b0;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        pc_src        = PC_SRC_ALU;
        alu_src_a     = 1'b0;
        alu_src_b     = ALU_B_RT;
        alu_opcode    = ALU_OP_ADD;
        alu_funcode   = ALU_FN_ADD;
        reg_write     = 1'b0;
        reg_dst       = REG_DST_RT;
        mem_to_reg    = M2R_ALU;
        out_write     = 1'b0;
        halted        = 1'b0;
        // gating on reset drops strobes the instant reset rises
        if (!reset) begin
            case (state_q)
                S_IF: begin
                    mem_read = 1'b1;
                    ir_write = 1'b1;
                end
                S_ID: begin
                    alu_src_b = ALU_B_ONE;
                    pc_write  = 1'b1;
                    if (ic == C_JMP || ic == C_JAL) pc_src = PC_SRC_JMP;
                end
                S_EX: begin
                    alu_opcode  = opcode;
                    alu_funcode = funcode;
                    alu_src_a   = 1'b1;
                    case (ic)
                        C_RALU:               alu_src_b = ALU_B_RT;
                        C_ADI, C_LWD, C_SWD:  alu_src_b = ALU_B_SEXT;
                        C_IMMZ:               alu_src_b = ALU_B_ZEXT;
                        C_BR: begin
                            pc_write_cond = 1'b1;
                            pc_src        = PC_SRC_BR;
                        end
                        C_WWD:                out_write = 1'b1;
                        C_JPR, C_JRL: begin
                            pc_write = 1'b1;
                            pc_src   = PC_SRC_RS;
                        end
                        default: ;
                    endcase
                end
                S_MEM: begin
                    i_or_d    = 1'b1;
                    mem_read  = (ic == C_LWD);
                    mem_write = (ic == C_SWD);
                end
                S_WB: begin
                    reg_write = 1'b1;
                    case (ic)
                        C_RALU: reg_dst = REG_DST_RD;
                        C_LWD:  mem_to_reg = M2R_MDR;
                        C_JAL, C_JRL: begin
                            reg_dst    = REG_DST_R2;
                            mem_to_reg = M2R_PC;
                        end
                        default: ;
                    endcase
                end
                S_HALT:  halted = 1'b1;
                default: ;
            endcase
        end
    end

`ifdef INST_COUNT_EN
    logic [WORD_SIZE-1:0] num_inst_q;
    logic [WORD_SIZE-1:0] num_inst_d;

    always_comb begin
        num_inst_d = num_inst_q;
        if (retire) num_inst_d = num_inst_q + 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) num_inst_q <= '0;
        else       num_inst_q <= num_inst_d;
    end

    assign num_inst = num_inst_q;
`else
    logic unused_retire;
    assign unused_retire = retire;
    localparam int unused_word_size = WORD_SIZE;
`endif

endmodule

// File: tb/tb_mc_control.sv
// Scoreboard bench for mc_control: per-instruction phase sequences are
// expanded into per-cycle expected outputs and checked by a monitor.
`timescale 1ns/1ps
module tb_mc_control;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] opcode = '0;
    logic [5:0] funcode = '0;
    logic       bcond = 1'b0;
    logic       mem_ready = 1'b0;
    logic       mem_read, mem_write, i_or_d, ir_write, pc_write;
    logic       pc_write_cond, alu_src_a, reg_write, out_write, halted;
    logic [1:0] pc_src, alu_src_b, reg_dst, mem_to_reg;
    logic [3:0] alu_opcode;
    logic [5:0] alu_funcode;
`ifdef INST_COUNT_EN
    logic [15:0] num_inst;
`endif

    always #5 clk = ~clk;

    mc_control #(.WORD_SIZE(16)) dut (
        .clk           (clk),
        .reset         (reset),
        .opcode        (opcode),
        .funcode       (funcode),
        .bcond         (bcond),
        .mem_ready     (mem_ready),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .i_or_d        (i_or_d),
        .ir_write      (ir_write),
        .pc_write      (pc_write),
        .pc_write_cond (pc_write_cond),
        .pc_src        (pc_src),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .alu_opcode    (alu_opcode),
        .alu_funcode   (alu_funcode),
        .reg_write     (reg_write),
        .reg_dst       (reg_dst),
        .mem_to_reg    (mem_to_reg),
        .out_write     (out_write),
        .halted        (halted)
`ifdef INST_COUNT_EN
        ,
        .num_inst      (num_inst)
`endif
    );

    typedef struct packed {
        logic       mem_read, mem_write, i_or_d, ir_write;
        logic       pc_write, pc_write_cond;
        logic [1:0] pc_src;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [3:0] alu_opcode;
        logic [5:0] alu_funcode;
        logic       reg_write;
        logic [1:0] reg_dst, mem_to_reg;
        logic       out_write, halted;
    } outs_t;

    typedef struct {
        outs_t exp;
        outs_t care;
        string name;
    } chk_t;

    outs_t act;
    assign act = {mem_read, mem_write, i_or_d, ir_write, pc_write,
                  pc_write_cond, pc_src, alu_src_a, alu_src_b, alu_opcode,
                  alu_funcode, reg_write, reg_dst, mem_to_reg, out_write,
                  halted};

    chk_t q[$];
    int   n_chk = 0;
    int   n_fail = 0;
    int   retired = 0;

    localparam int K_BR = 0, K_RT = 1, K_ADI = 2, K_ORI = 3, K_LHI = 4;
    localparam int K_LWD = 5, K_SWD = 6, K_JMP = 7, K_JAL = 8, K_JPR = 9;
    localparam int K_JRL = 10, K_WWD = 11, K_UND = 12, K_HLT = 13;
    localparam int PH_IF = 0, PH_ID = 1, PH_EX = 2, PH_MEM = 3;
    localparam int PH_WB = 4, PH_HALT = 5;

    // monitor: one scoreboard entry per clock cycle
    always @(negedge clk) begin
        chk_t c;
        if (q.size() > 0) begin
            c = q.pop_front();
            n_chk++;
            if (((act ^ c.exp) & c.care) !== '0) begin
                n_fail++;
                $display("FAIL %s: got %h want %h (care %h) t=%0t",
                         c.name, act, c.exp, c.care, $time);
            end
        end
    end

    task automatic chk_eq(input string nm, input logic [31:0] got,
                          input logic [31:0] want);
        n_chk++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h want %h t=%0t", nm, got, want, $time);
        end
    endtask

    function automatic outs_t reset_outs();
        outs_t e;
        e = '0;
        e.alu_opcode = 4'd15;
        return e;
    endfunction

    // expected outputs of one phase of an instruction of kind k
    function automatic void build(input int ph, input int k,
                                  input logic [3:0] op, input logic [5:0] fn,
                                  output outs_t e, output outs_t c);
        e = '0;
        c = '1;
        e.alu_opcode = 4'd15;
        case (ph)
            PH_IF: begin
                e.mem_read = 1'b1;
                e.ir_write = 1'b1;
            end
            PH_ID: begin
                e.alu_src_b = 2'd1;
                e.pc_write  = 1'b1;
                e.pc_src    = (k == K_JMP || k == K_JAL) ? 2'd2 : 2'd0;
            end
            PH_EX: begin
                e.alu_opcode  = op;
                e.alu_funcode = fn;
                c.alu_src_a   = 1'b0;
                if (k == K_RT) e.alu_src_b = 2'd0;
                else if (k == K_ADI || k == K_LWD || k == K_SWD) e.alu_src_b = 2'd2;
                else if (k == K_ORI || k == K_LHI) e.alu_src_b = 2'd3;
                else c.alu_src_b = 2'd0;
                if (k == K_BR) begin
                    e.pc_write_cond = 1'b1;
                    e.pc_src        = 2'd1;
                end
                if (k == K_WWD) e.out_write = 1'b1;
                if (k == K_JPR || k == K_JRL) begin
                    e.pc_write = 1'b1;
                    e.pc_src   = 2'd3;
                end
            end
            PH_MEM: begin
                e.i_or_d    = 1'b1;
                e.mem_read  = (k == K_LWD);
                e.mem_write = (k == K_SWD);
            end
            PH_WB: begin
                e.reg_write = 1'b1;
                if (k == K_RT) e.reg_dst = 2'd1;
                if (k == K_LWD) e.mem_to_reg = 2'd1;
                if (k == K_JAL || k == K_JRL) begin
                    e.reg_dst    = 2'd2;
                    e.mem_to_reg = 2'd2;
                end
            end
            default: e.halted = 1'b1;
        endcase
        if (ph != PH_IF && ph != PH_ID && ph != PH_EX) begin
            c.alu_opcode  = '0;
            c.alu_funcode = '0;
        end
    endfunction

    task automatic pick(input int k, output logic [3:0] op,
                        output logic [5:0] fn);
        fn = 6'($urandom);
        op = 4'd15;
        case (k)
            K_BR:  op = 4'($urandom_range(0, 3));
            K_RT:  fn = 6'($urandom_range(0, 7));
            K_ADI: op = 4'd4;
            K_ORI: op = 4'd5;
            K_LHI: op = 4'd6;
            K_LWD: op = 4'd7;
            K_SWD: op = 4'd8;
            K_JMP: op = 4'd9;
            K_JAL: op = 4'd10;
            K_JPR: fn = 6'd25;
            K_JRL: fn = 6'd26;
            K_WWD: fn = 6'd28;
            K_HLT: fn = 6'd29;
            default: begin
                if ($urandom_range(0, 1) == 1) begin
                    op = 4'($urandom_range(11, 14));
                end else begin
                    do fn = 6'($urandom);
                    while (fn < 6'd8 || fn == 6'd25 || fn == 6'd26 ||
                           fn == 6'd28 || fn == 6'd29);
                end
            end
        endcase
    endtask

    task automatic cyc(input int ph, input int k, input logic [3:0] op,
                       input logic [5:0] fn, input logic mr,
                       input string nm);
        chk_t t;
        build(ph, k, op, fn, t.exp, t.care);
        t.name = nm;
        mem_ready = mr;
        bcond = 1'($urandom);
        q.push_back(t);
        @(posedge clk);
        #1;
    endtask

    // phase sequence follows the cycles-per-instruction table
    task automatic run_op(input int k, input logic [3:0] op,
                          input logic [5:0] fn, input int if_wait,
                          input int mem_wait);
        bit has_ex, has_mem, has_wb;
        has_ex  = !(k == K_JMP || k == K_UND || k == K_JAL || k == K_HLT);
        has_mem = (k == K_LWD || k == K_SWD);
        has_wb  = !(k == K_JMP || k == K_UND || k == K_HLT || k == K_BR ||
                    k == K_WWD || k == K_JPR || k == K_SWD);
        opcode  = op;
        funcode = fn;
`ifdef INST_COUNT_EN
        chk_eq("num_inst", 32'(num_inst), 32'(16'(retired)));
`endif
        for (int w = 0; w <= if_wait; w++)
            cyc(PH_IF, k, op, fn, (w == if_wait), "IF");
        cyc(PH_ID, k, op, fn, 1'($urandom), "ID");
        if (has_ex) cyc(PH_EX, k, op, fn, 1'($urandom), "EX");
        if (has_mem)
            for (int w = 0; w <= mem_wait; w++)
                cyc(PH_MEM, k, op, fn, (w == mem_wait), "MEM");
        if (has_wb) cyc(PH_WB, k, op, fn, 1'($urandom), "WB");
        if (k != K_HLT) retired++;
    endtask

    task automatic run_rand(input int k);
        logic [3:0] op;
        logic [5:0] fn;
        int iw, mw;
        pick(k, op, fn);
        iw = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3)) : 0;
        mw = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3)) : 0;
        run_op(k, op, fn, iw, mw);
    endtask

    task automatic do_reset(input string nm);
        reset = 1'b1;
        #1;
        chk_eq({nm, "_async"}, 32'(act), 32'(reset_outs()));
        @(posedge clk);
        #1;
        chk_eq({nm, "_held"}, 32'(act), 32'(reset_outs()));
`ifdef INST_COUNT_EN
        chk_eq({nm, "_num_inst"}, 32'(num_inst), 32'd0);
`endif
        reset = 1'b0;
        retired = 0;
    endtask

    initial begin
        logic [3:0] op;
        logic [5:0] fn;
        chk_t t;
        @(posedge clk);
        #1;
        chk_eq("reset_outs", 32'(act), 32'(reset_outs()));
`ifdef INST_COUNT_EN
        chk_eq("reset_num_inst", 32'(num_inst), 32'd0);
`endif
        @(posedge clk);
        #1;
        reset = 1'b0;

        // directed cases, then HLT after five retirements
        run_op(K_RT, 4'd15, 6'd0, 0, 0);
        run_op(K_LWD, 4'd7, 6'h15, 3, 0);
        run_op(K_BR, 4'd0, 6'h2a, 0, 0);
        run_op(K_JAL, 4'd10, 6'h3f, 0, 0);
        run_op(K_JMP, 4'd9, 6'h01, 1, 0);
        run_op(K_HLT, 4'd15, 6'd29, 0, 0);
        for (int i = 0; i < 10; i++) begin
            cyc(PH_HALT, K_HLT, 4'd15, 6'd29, 1'($urandom), "HALT");
`ifdef INST_COUNT_EN
            chk_eq("halt_num_inst", 32'(num_inst), 32'd5);
`endif
        end
        do_reset("halt_reset");

        for (int i = 0; i < 150; i++) run_rand(int'($urandom_range(0, 12)));

        // reset in the MEM cycle of SWD while the write is outstanding
        pick(K_SWD, op, fn);
        opcode  = op;
        funcode = fn;
        cyc(PH_IF, K_SWD, op, fn, 1'b1, "IF");
        cyc(PH_ID, K_SWD, op, fn, 1'b0, "ID");
        cyc(PH_EX, K_SWD, op, fn, 1'b0, "EX");
        build(PH_MEM, K_SWD, op, fn, t.exp, t.care);
        t.name = "SWD_MEM";
        mem_ready = 1'b0;
        q.push_back(t);
        #6;
        do_reset("swd_reset");

        for (int i = 0; i < 40; i++) run_rand(int'($urandom_range(0, 12)));

        chk_eq("queue_drained", 32'(q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
